// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF evaluation arbiter: FSM encoding,
// response size and default timing constants.
package puf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_WAIT_DONE = 2'b01,
        ST_RELEASE   = 2'b10,
        ST_FAULT     = 2'b11
    } state_e;

    localparam int PUF_BITS    = 256;
    localparam int DEF_TIMEOUT = 200000;
    localparam int DEF_GUARD   = 2;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/puf_eval_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    localparam logic [IDX_W:0] N_L = (IDX_W + 1)'(NUM_REQ);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W:0]     w_sum;

    // Bit k of the rotated vector is requester (ptr + k) mod NUM_REQ.
    assign w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);

    // Scan from farthest to nearest so the nearest set bit wins.
    always_comb begin
        o_idx = '0;
        w_sum = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
            w_sum = (w_sum >= N_L) ? (w_sum - N_L) : w_sum;
            o_idx = w_rot[k] ? w_sum[IDX_W-1:0] : o_idx;
        end
        o_valid = |i_req;
    end

endmodule

// File: rtl/puf_eval_arbiter.sv
// Round-robin arbiter in front of the shared RO-PUF controller, with a
// start/done handshake, post-transaction guard interval and sticky watchdog.
module puf_eval_arbiter
    import puf_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1,
    parameter int TO_W    = 18,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GUARD   = DEF_GUARD
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] err,
    output logic               fault,
    output logic               busy,
    output logic [IDX_W-1:0]   sel,
    output logic               puf_start,
    input  logic               puf_done
);

    localparam int                 GD_W    = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [TO_W-1:0]    WD_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [GD_W-1:0]    GD_LAST = GD_W'(GUARD - 1);
    localparam logic [NUM_REQ-1:0] ONE     = {{(NUM_REQ-1){1'b0}}, 1'b1};

    state_e             r_state;
    logic [NUM_REQ-1:0] r_gnt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] r_err;
    logic               r_fault;
    logic               r_busy;
    logic [IDX_W-1:0]   r_sel;
    logic               r_start;
    logic [IDX_W-1:0]   r_ptr;
    logic [TO_W-1:0]    r_wdog;
    logic [GD_W-1:0]    r_guard;

    logic               w_valid;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_next_ptr;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign w_next_ptr = IDX_W'(wrap_inc(int'(w_idx), NUM_REQ));

    // Arbitration FSM with watchdog and guard counters; every output is a register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_ack   <= '0;
            r_err   <= '0;
            r_fault <= 1'b0;
            r_busy  <= 1'b0;
            r_sel   <= '0;
            r_start <= 1'b0;
            r_ptr   <= '0;
            r_wdog  <= '0;
            r_guard <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_gnt   <= ONE << w_idx;
                        r_sel   <= w_idx;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_next_ptr;
                        r_wdog  <= '0;
                        r_state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    // Done takes priority over a watchdog expiry in the same cycle.
                    if (puf_done) begin
                        r_ack   <= ONE << r_sel;
                        r_gnt   <= '0;
                        r_start <= 1'b0;
                        r_guard <= '0;
                        r_state <= ST_RELEASE;
                    end else if (r_wdog == WD_LAST) begin
                        r_err   <= ONE << r_sel;
                        r_gnt   <= '0;
                        r_start <= 1'b0;
                        r_fault <= 1'b1;
                        r_state <= ST_FAULT;
                    end else if (r_wdog != '1) begin
                        r_wdog <= r_wdog + TO_W'(1'b1);
                    end
                end
                ST_RELEASE: begin
                    if (r_guard == GD_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_guard <= r_guard + GD_W'(1'b1);
                    end
                end
                ST_FAULT: begin
                    r_gnt   <= '0;
                    r_start <= 1'b0;
                    r_busy  <= 1'b1;
                end
                default: begin
                    r_gnt   <= '0;
                    r_start <= 1'b0;
                    r_busy  <= 1'b1;
                    r_fault <= 1'b1;
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign ack       = r_ack;
    assign err       = r_err;
    assign fault     = r_fault;
    assign busy      = r_busy;
    assign sel       = r_sel;
    assign puf_start = r_start;

endmodule
